// File: rtl/d_cache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller, 8 x 128-bit lines.
// Optional hit/miss statistics counters are enabled by defining DCACHE_STATS_EN.
module d_cache_ctrl #(
  parameter int MEM_LAT = 2
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         C_REQ,
  input  logic         C_WE,
  input  logic [13:0]  C_ADDR,
  input  logic [3:0]   C_BE,
  input  logic [31:0]  C_WDATA,
  output logic [31:0]  C_RDATA,
  output logic         C_READY,
  output logic         D_MEM_CSN,
  output logic         D_MEM_WEN,
  output logic [9:0]   D_MEM_ADDR,
  output logic [127:0] D_MEM_DOUT,
  input  logic [127:0] D_MEM_DI,
  output logic [31:0]  HIT_CNT,
  output logic [31:0]  MISS_CNT
);

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESP} state_t;

  state_t       state_reg;
  logic [127:0] data_mem [8];
  logic [6:0]   tag_mem [8];
  logic [7:0]   valid_reg;
  logic [7:0]   dirty_reg;
  logic [3:0]   cnt_reg;
  logic         req_we_reg;
  logic [11:0]  req_addr_reg;
  logic [3:0]   req_be_reg;
  logic [31:0]  req_wdata_reg;

  logic [6:0]   req_tag;
  logic [2:0]   req_idx;
  logic [1:0]   req_word;
  logic [127:0] cur_line;
  logic [127:0] merged_line;
  logic         hit;
  logic         last_cycle;
  logic         unused_addr_bits;

  assign req_tag          = req_addr_reg[11:5];
  assign req_idx          = req_addr_reg[4:2];
  assign req_word         = req_addr_reg[1:0];
  assign cur_line         = data_mem[req_idx];
  assign hit              = valid_reg[req_idx] && (tag_mem[req_idx] == req_tag);
  assign last_cycle       = (cnt_reg == 4'(MEM_LAT - 1));
  assign unused_addr_bits = ^C_ADDR[1:0];

  // Byte lane gi of the line takes store data only inside the addressed word.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_merge
      assign merged_line[gi*8 +: 8] =
        (req_word == 2'(gi / 4) && req_be_reg[gi % 4]) ?
        req_wdata_reg[(gi % 4)*8 +: 8] : cur_line[gi*8 +: 8];
    end
  endgenerate

  // Data and tag arrays carry no reset; valid bits gate their use.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (state_reg == REFILL && last_cycle) begin
        data_mem[req_idx] <= D_MEM_DI;
        tag_mem[req_idx]  <= req_tag;
      end else if (state_reg == RESP && req_we_reg) begin
        data_mem[req_idx] <= merged_line;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_reg;
  logic [31:0] miss_cnt_reg;
  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else if (state_reg == LOOKUP) begin
      if (hit) hit_cnt_reg  <= hit_cnt_reg + 32'd1;
      else     miss_cnt_reg <= miss_cnt_reg + 32'd1;
    end
  end
  assign HIT_CNT  = hit_cnt_reg;
  assign MISS_CNT = miss_cnt_reg;
`else
  assign HIT_CNT  = '0;
  assign MISS_CNT = '0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= IDLE;
      valid_reg     <= '0;
      dirty_reg     <= '0;
      cnt_reg       <= '0;
      req_we_reg    <= 1'b0;
      req_addr_reg  <= '0;
      req_be_reg    <= '0;
      req_wdata_reg <= '0;
      C_READY       <= 1'b0;
      C_RDATA       <= '0;
      D_MEM_CSN     <= 1'b1;
      D_MEM_WEN     <= 1'b1;
      D_MEM_ADDR    <= '0;
      D_MEM_DOUT    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (C_REQ) begin
            req_we_reg    <= C_WE;
            req_addr_reg  <= C_ADDR[13:2];
            req_be_reg    <= C_BE;
            req_wdata_reg <= C_WDATA;
            state_reg     <= LOOKUP;
          end
        end
        LOOKUP: begin
          cnt_reg <= '0;
          if (hit) begin
            state_reg <= RESP;
            C_READY   <= 1'b1;
            C_RDATA   <= req_we_reg ? 32'd0 : cur_line[{req_word, 5'd0} +: 32];
          end else if (valid_reg[req_idx] && dirty_reg[req_idx]) begin
            state_reg  <= WRITEBACK;
            D_MEM_CSN  <= 1'b0;
            D_MEM_WEN  <= 1'b0;
            D_MEM_ADDR <= {tag_mem[req_idx], req_idx};
            D_MEM_DOUT <= cur_line;
          end else begin
            state_reg  <= REFILL;
            D_MEM_CSN  <= 1'b0;
            D_MEM_WEN  <= 1'b1;
            D_MEM_ADDR <= {req_tag, req_idx};
          end
        end
        WRITEBACK: begin
          if (last_cycle) begin
            state_reg  <= REFILL;
            cnt_reg    <= '0;
            D_MEM_WEN  <= 1'b1;
            D_MEM_ADDR <= {req_tag, req_idx};
            D_MEM_DOUT <= '0;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        REFILL: begin
          if (last_cycle) begin
            state_reg          <= RESP;
            D_MEM_CSN          <= 1'b1;
            D_MEM_ADDR         <= '0;
            valid_reg[req_idx] <= 1'b1;
            dirty_reg[req_idx] <= 1'b0;
            C_READY            <= 1'b1;
            C_RDATA            <= req_we_reg ? 32'd0 : D_MEM_DI[{req_word, 5'd0} +: 32];
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        RESP: begin
          C_READY   <= 1'b0;
          C_RDATA   <= '0;
          state_reg <= IDLE;
          if (req_we_reg) dirty_reg[req_idx] <= 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
